rgmii_rx_framer: RTL and testbench

RGMII_RX_FRAMER -- requirements
Module: rgmii_rx_framer

---
 rtl/eth_pkg.sv | 6 +
 rtl/rgmii_rx_framer.sv | 97 +++++++++
 tb/tb_rgmii_rx_framer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet receive constants and framer state type
package eth_pkg;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} rx_state_t;
endpackage

// File: rtl/rgmii_rx_framer.sv
// rgmii_rx_framer: strips preamble/SFD from RGMII receive bytes and streams the payload as AXI-Stream
module rgmii_rx_framer
    import eth_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = 1518
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rxd_rise,
    input  logic [3:0] rxd_fall,
    input  logic       rx_ctl_rise,
    input  logic       rx_ctl_fall,
    output logic [7:0] m_rx_axis_tdata,
    output logic       m_rx_axis_tvalid,
    output logic       m_rx_axis_tlast,
    output logic       m_rx_axis_tuser
);
    localparam logic [10:0] MAX_COUNT = 11'(MAX_FRAME_BYTES);

    logic [7:0]  byte_q;
    logic        dv_q;
    logic        er_q;
    rx_state_t   state;
    rx_state_t   state_n;
    logic [7:0]  hold;
    logic        hold_valid;
    logic [10:0] count;
    logic        err_flag;
    logic        full;
    logic        accept;
    logic [7:0]  d_n;
    logic        v_n;
    logic        l_n;
    logic        u_n;

    assign full   = count == MAX_COUNT;
    assign accept = state == PAYLOAD && dv_q && !full;

    // register the DDR samples into a byte plus decoded data-valid and error
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q <= '0;
            dv_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            byte_q <= {rxd_fall, rxd_rise};
            dv_q   <= rx_ctl_rise;
            er_q   <= rx_ctl_rise ^ rx_ctl_fall;
        end
    end

    // framer state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // an errored or unexpected byte outside the payload drops the rest of the burst
    always_comb begin
        state_n = !dv_q              ? IDLE :
                  state == PAYLOAD   ? (full ? DROP : PAYLOAD) :
                  state == DROP || er_q ? DROP :
                  byte_q == SFD_BYTE      ? PAYLOAD :
                  byte_q == PREAMBLE_BYTE ? PREAMBLE : DROP;
    end

    // the held byte leaves when the next byte arrives, or as the last byte when dv drops or the frame overflows
    always_comb begin
        v_n = state == PAYLOAD && hold_valid;
        l_n = v_n && (!dv_q || full);
        u_n = v_n && (dv_q ? full : err_flag);
        d_n = v_n ? hold : m_rx_axis_tdata;
    end

    // hold register, byte counter, sticky error and registered stream outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            hold             <= '0;
            hold_valid       <= 1'b0;
            count            <= '0;
            err_flag         <= 1'b0;
            m_rx_axis_tdata  <= '0;
            m_rx_axis_tvalid <= 1'b0;
            m_rx_axis_tlast  <= 1'b0;
            m_rx_axis_tuser  <= 1'b0;
        end else begin
            hold             <= accept ? byte_q : hold;
            hold_valid       <= accept;
            count            <= accept ? count + 11'd1 : '0;
            err_flag         <= accept && (err_flag || er_q);
            m_rx_axis_tdata  <= d_n;
            m_rx_axis_tvalid <= v_n;
            m_rx_axis_tlast  <= l_n;
            m_rx_axis_tuser  <= u_n;
        end
    end
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// tb_rgmii_rx_framer: frame-level model and per-cycle stream checker for rgmii_rx_framer
module tb_rgmii_rx_framer;
    localparam int MAXB = 64;

    typedef struct {
        logic [7:0] d;
        logic       l;
        logic       u;
    } beat_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] rxd_rise = '0;
    logic [3:0] rxd_fall = '0;
    logic       rx_ctl_rise = 1'b0;
    logic       rx_ctl_fall = 1'b0;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tlast;
    logic       tuser;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         beats = 0;
    int         beat_cyc[int];
    logic       rst_d = 1'b1;
    logic [7:0] exp_hold = '0;
    beat_t      q[$];
    logic [7:0] fb[$];
    bit         fe[$];

    rgmii_rx_framer #(.MAX_FRAME_BYTES(MAXB)) dut (
        .clk(clk),
        .reset(reset),
        .rxd_rise(rxd_rise),
        .rxd_fall(rxd_fall),
        .rx_ctl_rise(rx_ctl_rise),
        .rx_ctl_fall(rx_ctl_fall),
        .m_rx_axis_tdata(tdata),
        .m_rx_axis_tvalid(tvalid),
        .m_rx_axis_tlast(tlast),
        .m_rx_axis_tuser(tuser)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= reset;
    end

    // compare every cycle's outputs against the model's expected beat stream
    always @(negedge clk) begin
        beat_t e;
        checks++;
        if (rst_d) begin
            exp_hold = '0;
            if (tdata !== 8'h00 || tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0) begin
                errors++;
                $display("FAIL reset_out got d=%h v=%b l=%b u=%b exp all zero", tdata, tvalid, tlast, tuser);
            end
        end else if (tvalid === 1'b1) begin
            beat_cyc[beats] = cyc;
            beats++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got d=%h l=%b u=%b exp no beat (cyc %0d)", tdata, tlast, tuser, cyc);
            end else begin
                e = q.pop_front();
                exp_hold = e.d;
                if (tdata !== e.d || tlast !== e.l || tuser !== e.u) begin
                    errors++;
                    $display("FAIL beat got d=%h l=%b u=%b exp d=%h l=%b u=%b (cyc %0d)",
                             tdata, tlast, tuser, e.d, e.l, e.u, cyc);
                end
            end
        end else if (tvalid !== 1'b0 || tlast !== 1'b0 || tuser !== 1'b0 || tdata !== exp_hold) begin
            errors++;
            $display("FAIL idle got d=%h v=%b l=%b u=%b exp d=%h v=0 l=0 u=0 (cyc %0d)",
                     tdata, tvalid, tlast, tuser, exp_hold, cyc);
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic dv, input logic er);
        rxd_rise    = b[3:0];
        rxd_fall    = b[7:4];
        rx_ctl_rise = dv;
        rx_ctl_fall = dv ^ er;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h00, 1'b0, 1'b0);
    endtask

    task automatic build(input int npre, input int plen, input int er_at, input int start);
        fb.delete();
        fe.delete();
        for (int i = 0; i < npre; i++) begin
            fb.push_back(8'h55);
            fe.push_back(1'b0);
        end
        fb.push_back(8'hD5);
        fe.push_back(1'b0);
        for (int k = 1; k <= plen; k++) begin
            fb.push_back(8'(start + k - 1));
            fe.push_back(k == er_at);
        end
    endtask

    // frame model: clean 0x55s then a clean SFD open a frame; the payload is truncated at MAXB with error
    task automatic model();
        int  i = 0;
        int  plen;
        int  n;
        bit  err;
        while (i < fb.size() && fb[i] == 8'h55 && !fe[i]) i++;
        if (i >= fb.size() || fb[i] != 8'hD5 || fe[i]) return;
        plen = fb.size() - i - 1;
        n    = plen > MAXB ? MAXB : plen;
        err  = plen > MAXB;
        for (int k = 0; k < n; k++) err |= fe[i + 1 + k];
        for (int k = 0; k < n; k++) q.push_back('{fb[i + 1 + k], k == n - 1, k == n - 1 && err});
    endtask

    task automatic send();
        model();
        foreach (fb[i]) drive(fb[i], 1'b1, fe[i]);
        drive(8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int b0;
        int c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tdata", int'(tdata), 0);
        chk("reset_tvalid", int'(tvalid), 0);
        reset = 1'b0;
        idle(2);

        b0 = beats;
        c  = cyc;
        build(7, 64, 0, 1);
        send();
        idle(3);
        chk("basic_beats", beats - b0, 64);
        chk("basic_first_latency", beat_cyc[b0] - c, 11);
        chk("basic_last_cycle", beat_cyc[b0 + 63] - c, 74);

        b0 = beats;
        build(7, 64, 10, 1);
        send();
        idle(3);
        chk("er_beats", beats - b0, 64);

        b0 = beats;
        fb = '{8'h55, 8'h55, 8'h5A, 8'h01, 8'h02, 8'h03};
        fe = '{0, 0, 0, 0, 0, 0};
        send();
        build(7, 8, 0, 8'h30);
        send();
        idle(3);
        chk("bad_preamble_then_good_beats", beats - b0, 8);

        b0 = beats;
        build(0, 1, 0, 8'hAB);
        send();
        idle(3);
        chk("sfd_only_one_byte_beats", beats - b0, 1);
        chk("sfd_only_one_byte_data", int'(tdata), 8'hAB);

        b0 = beats;
        build(3, 0, 0, 0);
        send();
        idle(3);
        chk("empty_frame_beats", beats - b0, 0);

        b0 = beats;
        build(7, 70, 0, 1);
        send();
        build(7, 5, 0, 8'h80);
        send();
        idle(3);
        chk("oversize_then_next_beats", beats - b0, 69);

        b0 = beats;
        build(7, 65, 0, 1);
        send();
        idle(3);
        chk("oversize_by_one_beats", beats - b0, 64);

        b0 = beats;
        build(7, 4, 0, 1);
        fe[3] = 1'b1;
        send();
        idle(2);
        chk("er_in_preamble_beats", beats - b0, 0);

        b0 = beats;
        for (int k = 1; k <= 17; k++) q.push_back('{8'(k), 1'b0, 1'b0});
        repeat (7) drive(8'h55, 1'b1, 1'b0);
        drive(8'hD5, 1'b1, 1'b0);
        for (int k = 1; k <= 19; k++) drive(8'(k), 1'b1, 1'b0);
        reset = 1'b1;
        drive(8'd20, 1'b1, 1'b0);
        reset = 1'b0;
        for (int k = 21; k <= 30; k++) drive(8'(k), 1'b1, 1'b0);
        idle(3);
        chk("reset_midframe_beats", beats - b0, 17);
        chk("reset_midframe_tdata", int'(tdata), 0);

        b0 = beats;
        build(7, 12, 0, 8'h60);
        send();
        idle(5);
        chk("after_reset_beats", beats - b0, 12);
        chk("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
